// File: rtl/serial_adder_defs.sv
// serial_adder_defs: shared definitions for the bit-serial adder.
//   state_e   - controller state encoding (IDLE/SHIFT/DONE)
//   N_DEFAULT - default operand/sum width
package serial_adder_defs;

  localparam int unsigned N_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/one_bit_full_adder.sv
// one_bit_full_adder: gate-level 1-bit full adder cell.
// Ports:
//   a, b, cin : input bits
//   s         : sum bit      (a ^ b ^ cin)
//   cout      : carry out    (a&b | cin&(a^b))
module one_bit_full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic ab_x;
  logic ab_a;
  logic cx_a;

  xor g_x1 (ab_x, a, b);
  xor g_x2 (s, ab_x, cin);
  and g_a1 (ab_a, a, b);
  and g_a2 (cx_a, ab_x, cin);
  or  g_o1 (cout, ab_a, cx_a);

endmodule

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial N-bit adder around a single full-adder cell.
// Operands are captured on an accepted start and fed LSB first, one bit
// pair per cycle; the carry is registered between cycles. After N SHIFT
// cycles the result is presented for one DONE cycle and then held.
// Parameters:
//   N     - operand/sum width (N >= 2)
// Ports:
//   clk   - rising-edge clock
//   rst   - asynchronous active-high reset
//   start - request, sampled in IDLE or DONE
//   a, b  - operands, captured on accepted start
//   cin   - initial carry, captured on accepted start
//   busy  - high while shifting
//   done  - one-cycle pulse, sum/cout valid
//   sum   - result, held until the next accepted start's completion
//   cout  - final carry, held with sum
//   ovf   - signed overflow flag (only with SERIAL_ADDER_OVF_EN defined)
// Optional feature macro: SERIAL_ADDER_OVF_EN
module serial_adder_ctrl
  import serial_adder_defs::*;
#(
  parameter int unsigned N = N_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] sum,
`ifdef SERIAL_ADDER_OVF_EN
  output logic         ovf,
`endif
  output logic         cout
);

  localparam int unsigned CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_e        state_q, state_d;
  logic [N-1:0]  a_sr_q, a_sr_d;
  logic [N-1:0]  b_sr_q, b_sr_d;
  logic [N-1:0]  sum_sr_q, sum_sr_d;
  logic          carry_q, carry_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  sum_q, sum_d;
  logic          cout_q, cout_d;
`ifdef SERIAL_ADDER_OVF_EN
  logic          ovf_q, ovf_d;
`endif

  logic fa_s;
  logic fa_cout;

  one_bit_full_adder u_fa (
    .a    (a_sr_q[0]),
    .b    (b_sr_q[0]),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_cout)
  );

  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    sum_sr_d = sum_sr_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d    = ovf_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_sr_d  = a;
          b_sr_d  = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        sum_sr_d = {fa_s, sum_sr_q[N-1:1]};
        carry_d  = fa_cout;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = DONE;
          // Result registers load with the final bit on the same edge
          // that enters DONE, so sum/cout are valid with the done pulse.
          sum_d   = {fa_s, sum_sr_q[N-1:1]};
          cout_d  = fa_cout;
`ifdef SERIAL_ADDER_OVF_EN
          // carry_q here is the carry into the MSB.
          ovf_d   = carry_q ^ fa_cout;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      sum_sr_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      sum_sr_q <= sum_sr_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign busy = (state_q == SHIFT);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule
